// File: rtl/vram_arbiter.sv
// Arbitrates one single-port VRAM between 4x-scaled scanout fetches and a CPU port
// whose writes are posted into a FIFO and retired during blanking.
module vram_arbiter #(
   parameter int unsigned H_ACTIVE            = 640,
   parameter int unsigned V_ACTIVE            = 480,
   parameter int unsigned FB_WIDTH            = 160,
   parameter int unsigned ADDR_WIDTH          = 15,
   parameter int unsigned WFIFO_DEPTH         = 16,
   parameter int unsigned WRITE_IN_BLANK_ONLY = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [9:0]            hpos,
   input  logic [9:0]            vpos,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [7:0]            cpu_wdata,
   output logic                  cpu_ack,
   output logic [7:0]            cpu_rdata,
   output logic                  wfifo_full,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata,
   output logic [7:0]            pix_index,
   output logic                  pix_valid
);

   localparam int unsigned PTR_W = $clog2(WFIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] r_fifo_addr [WFIFO_DEPTH];
   logic [7:0]            r_fifo_data [WFIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_ack;
   logic                  r_rd_ack;
   logic [ADDR_WIDTH-1:0] r_last_addr;
   logic                  r_fetch_d1;
   logic                  r_act_d1;
   logic                  r_act_d2;
   logic [7:0]            r_pix;

   logic                  w_active;
   logic                  w_vid_slot;
   logic [ADDR_WIDTH-1:0] w_vaddr;
   logic                  w_fifo_empty;
   logic                  w_full;
   logic                  w_rd_issue;
   logic                  w_retire;
   logic                  w_push;
   logic                  w_issue;

   assign w_active     = (hpos < 10'(H_ACTIVE)) && (vpos < 10'(V_ACTIVE));
   assign w_vid_slot   = reset_n && w_active && (hpos[1:0] == 2'b00);
   assign w_vaddr      = ADDR_WIDTH'(vpos[9:2]) * ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(hpos[9:2]);
   assign w_fifo_empty = (r_count == '0);
   assign w_full       = (r_count == CNT_W'(WFIFO_DEPTH));

   // Slot priority: video fetch, then CPU read (only with no posted writes), then write retire
   assign w_rd_issue = reset_n && !w_vid_slot && cpu_req && !cpu_we && w_fifo_empty && !r_ack;
   assign w_retire   = reset_n && !w_vid_slot && !w_fifo_empty &&
                       (!w_active || (WRITE_IN_BLANK_ONLY == 0));
   assign w_push     = reset_n && cpu_req && cpu_we && !w_full && !r_ack;
   assign w_issue    = w_vid_slot || w_rd_issue || w_retire;

   always_comb begin
      mem_addr  = r_last_addr;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (w_vid_slot) begin
         mem_addr = w_vaddr;
      end else if (w_rd_issue) begin
         mem_addr = cpu_addr;
      end else if (w_retire) begin
         mem_addr  = r_fifo_addr[r_rd_ptr];
         mem_we    = 1'b1;
         mem_wdata = r_fifo_data[r_rd_ptr];
      end
   end

   // Posted-write storage; validity is tracked by the pointers and count alone
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= cpu_addr;
         r_fifo_data[r_wr_ptr] <= cpu_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_ack       <= 1'b0;
         r_rd_ack    <= 1'b0;
         r_last_addr <= '0;
         r_fetch_d1  <= 1'b0;
         r_act_d1    <= 1'b0;
         r_act_d2    <= 1'b0;
         r_pix       <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_retire) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_retire) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_retire && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
         r_ack    <= w_push || w_rd_issue;
         r_rd_ack <= w_rd_issue;
         if (w_issue) begin
            r_last_addr <= mem_addr;
         end
         // RAM data for a fetch lands one cycle later and is captured on the following edge
         r_fetch_d1 <= w_vid_slot;
         if (r_fetch_d1) begin
            r_pix <= mem_rdata;
         end
         r_act_d1 <= w_active;
         r_act_d2 <= r_act_d1;
      end
   end

   assign cpu_ack    = r_ack;
   assign cpu_rdata  = r_rd_ack ? mem_rdata : '0;
   assign wfifo_full = w_full;
   assign pix_index  = r_pix;
   assign pix_valid  = r_act_d2;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: queue-based reference model checked every negedge,
// directed scenarios with literal expectations, then randomized scanout plus CPU traffic.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  hpos, vpos;
   logic        cpu_req, cpu_we;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        wfifo_full;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic [7:0]  pix_index;
   logic        pix_valid;

   int n_cmp = 0;
   int n_bad = 0;

   vram_arbiter dut (
      .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .wfifo_full(wfifo_full),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .pix_index(pix_index), .pix_valid(pix_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t hpos=%0d vpos=%0d)",
                  name, act, exp, $time, hpos, vpos);
      end
   endtask

   // Synchronous single-port RAM, read-first, one cycle read latency
   bit [7:0] ram [0:32767];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // Reference model
   typedef struct packed { logic [14:0] a; logic [7:0] d; } wr_t;
   wr_t         wq[$];
   bit [7:0]    mmem [0:32767];
   bit          m_ack, m_ack_rd, m_f1, m_a1, m_a2;
   logic [7:0]  m_rdata, m_f1_val, m_pix;
   logic [14:0] m_last;

   always @(negedge clk) begin : model
      bit act, vs, rd, ret, psh, ewe;
      int va;
      logic [14:0] ea;
      logic [7:0] ewd;
      wr_t w;
      if (!reset_n) begin
         wq.delete();
         m_ack = 0; m_ack_rd = 0; m_f1 = 0; m_a1 = 0; m_a2 = 0;
         m_rdata = '0; m_f1_val = '0; m_pix = '0; m_last = '0;
         check("reset_outputs",
               {cpu_ack, cpu_rdata, wfifo_full, mem_addr, mem_we, mem_wdata, pix_index, pix_valid},
               48'd0);
      end else begin
         act = (hpos < 640) && (vpos < 480);
         vs  = act && (hpos % 4 == 0);
         va  = ((int'(vpos) / 4) * 160 + int'(hpos) / 4) % 32768;
         rd  = !vs && cpu_req && !cpu_we && wq.size() == 0 && !m_ack;
         ret = !vs && wq.size() != 0 && !act;
         psh = cpu_req && cpu_we && wq.size() < 16 && !m_ack;
         ewe = 0; ewd = '0; ea = m_last;
         if (vs) ea = 15'(va);
         else if (rd) ea = cpu_addr;
         else if (ret) begin ea = wq[0].a; ewe = 1; ewd = wq[0].d; end

         check("cpu_ack", cpu_ack, m_ack);
         if (m_ack && m_ack_rd) check("cpu_rdata", cpu_rdata, m_rdata);
         check("wfifo_full", wfifo_full, wq.size() == 16);
         check("mem_we", mem_we, ewe);
         check("mem_addr", mem_addr, ea);
         if (ewe) check("mem_wdata", mem_wdata, ewd);
         check("pix_valid", pix_valid, m_a2);
         check("pix_index", pix_index, m_pix);

         if (vs || rd || ret) m_last = ea;
         m_ack_rd = rd;
         if (rd) m_rdata = mmem[cpu_addr];
         m_ack = rd || psh;
         if (m_f1) m_pix = m_f1_val;
         m_f1 = vs;
         if (vs) m_f1_val = mmem[va];
         m_a2 = m_a1;
         m_a1 = act;
         if (ret) begin w = wq.pop_front(); mmem[w.a] = w.d; end
         if (psh) wq.push_back({cpu_addr, cpu_wdata});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic adv();
      tick();
      hpos = (hpos == 10'd799) ? 10'd0 : hpos + 10'd1;
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int acks, seen, early, ackpos, n;
      bit busy;
      reset_n = 1'b0; hpos = '0; vpos = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;

      // Reset with random inputs
      for (int i = 0; i < 5; i++) begin
         tick();
         hpos = 10'($urandom_range(0, 799)); vpos = 10'($urandom_range(0, 524));
         cpu_req = 1'($urandom); cpu_we = 1'($urandom);
         cpu_addr = 15'($urandom); cpu_wdata = 8'($urandom);
         #1;
         check("rst_ack", cpu_ack, 0);
         check("rst_we", mem_we, 0);
         check("rst_addr", mem_addr, 0);
         check("rst_pixv", pix_valid, 0);
      end
      tick();
      reset_n = 1'b1; cpu_req = 0; hpos = 10'd700; vpos = 10'd500;
      for (int i = 0; i < 4; i++) begin
         adv();
         check("post_rst_pixv", pix_valid, 0);
      end

      // Blank-only retire of a write accepted in active video
      adv(); hpos = 10'd100; vpos = 10'd10;
      cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0123; cpu_wdata = 8'h77;
      adv();
      check("bw_ack", cpu_ack, 1);
      cpu_req = 0;
      seen = 0;
      #1; if (mem_we) seen++;
      while (hpos != 10'd639) begin adv(); #1; if (mem_we) seen++; end
      check("bw_hold", seen, 0);
      adv(); #1;
      check("bw_we", mem_we, 1);
      check("bw_addr", mem_addr, 15'h0123);
      check("bw_data", mem_wdata, 8'h77);

      // Place 0x5A at byte 162 during blank, then scan it out
      adv(); cpu_req = 1; cpu_we = 1; cpu_addr = 15'd162; cpu_wdata = 8'h5A;
      adv(); cpu_req = 0;
      for (int i = 0; i < 4; i++) adv();
      adv(); hpos = 10'd8; vpos = 10'd4; #1;
      check("scan_addr", mem_addr, 15'd162);
      check("scan_we", mem_we, 0);
      adv(); adv();
      check("scan_pix", pix_index, 8'h5A);
      check("scan_pixv", pix_valid, 1);

      // Fill the FIFO in active video; 17th write waits for the first blank pop
      adv(); hpos = 10'd0; vpos = 10'd20;
      n = 0; acks = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 15'h200; cpu_wdata = 8'hA0;
      while (hpos != 10'd639) begin
         adv();
         if (cpu_ack) begin
            acks++; n++;
            cpu_addr = 15'h200 + 15'(n); cpu_wdata = 8'hA0 + 8'(n);
         end
      end
      check("full_acks", acks, 16);
      check("full_flag", wfifo_full, 1);
      adv(); #1;
      check("full_pop0_we", mem_we, 1);
      check("full_pop0_addr", mem_addr, 15'h200);
      ackpos = 0;
      for (int k = 1; k <= 16; k++) begin
         adv();
         if (cpu_ack) begin ackpos = int'(hpos); cpu_req = 0; end
         #1;
         check("full_order_addr", mem_addr, 15'h200 + 15'(k));
         check("full_order_data", mem_wdata, 8'hA0 + 8'(k));
      end
      check("full_17th_ack_pos", ackpos, 642);

      // Read after a posted write waits for the drain and returns the new byte
      adv(); hpos = 10'd100; vpos = 10'd30;
      cpu_req = 1; cpu_we = 1; cpu_addr = 15'd100; cpu_wdata = 8'h33;
      adv();
      check("raw_wack", cpu_ack, 1);
      cpu_we = 0;
      early = 0;
      while (hpos != 10'd639) begin adv(); if (cpu_ack) early++; end
      check("raw_no_early_ack", early, 0);
      adv(); #1;
      check("raw_retire", {mem_we, mem_addr}, {1'b1, 15'd100});
      adv(); #1;
      check("raw_issue", {mem_we, mem_addr}, {1'b0, 15'd100});
      adv();
      check("raw_ack", cpu_ack, 1);
      check("raw_rdata", cpu_rdata, 8'h33);
      cpu_req = 0;

      // Read colliding with a video slot slips exactly one cycle
      adv(); hpos = 10'd200; vpos = 10'd30;
      cpu_req = 1; cpu_we = 0; cpu_addr = 15'd5;
      #1;
      check("coll_vaddr", mem_addr, 15'd1170);
      adv();
      check("coll_no_ack", cpu_ack, 0);
      #1;
      check("coll_issue", mem_addr, 15'd5);
      adv();
      check("coll_ack", cpu_ack, 1);
      cpu_req = 0;

      // Reset with five queued writes discards them
      adv(); hpos = 10'd0; vpos = 10'd40;
      n = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 15'h300; cpu_wdata = 8'h11;
      for (int i = 0; i < 40; i++) begin
         adv();
         if (cpu_ack && n < 5) begin
            n++;
            if (n == 5) cpu_req = 0;
            else begin cpu_addr = 15'h300 + 15'(n); cpu_wdata = 8'h11 + 8'(n); end
         end
      end
      check("mid_rst_queued", n, 5);
      adv(); reset_n = 1'b0; #1;
      check("mid_rst_we", mem_we, 0);
      adv(); reset_n = 1'b1;
      adv(); hpos = 10'd640;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         adv(); #1;
         if (mem_we || cpu_ack || wfifo_full) seen++;
      end
      check("mid_rst_quiet", seen, 0);

      // Randomized scanout with CPU traffic
      busy = 0;
      for (int line = 0; line < 30; line++) begin
         int v;
         v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(480, 524)) : int'($urandom_range(0, 51));
         for (int h = 0; h < 800; h++) begin
            tick();
            hpos = 10'(h); vpos = 10'(v);
            reset_n = !(line == 15 && h == 300);
            if (cpu_ack) begin busy = 0; cpu_req = 0; end
            if (!busy && $urandom_range(0, 3) == 0) begin
               busy = 1; cpu_req = 1;
               cpu_we = ($urandom_range(0, 9) < 7);
               cpu_addr = 15'($urandom_range(0, 2047));
               cpu_wdata = 8'($urandom);
            end
         end
      end
      tick();
      cpu_req = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the HDMI scanout path and a CPU-side requester.
- Scanout reads one byte per 4 screen pixels. The framebuffer is 160x120 palette indices scaled 4x onto 640x480.
- CPU writes are posted into a FIFO and retired only in blanking, so writes cannot tear the visible frame. CPU reads use free slots and are ordered behind pending writes.
- Sits between the hdmi timing block (hpos/vpos) and the colour lookup that drives red/green/blue.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- FB_WIDTH, 160, framebuffer bytes per row
- ADDR_WIDTH, 15, VRAM address width
- WFIFO_DEPTH, 16, posted-write FIFO entries (power of 2)
- WRITE_IN_BLANK_ONLY, 1, 1 = retire writes only while blanked; 0 = retire in any free slot

Ports:
- clk  in  1  pixel clock; hpos advances once per clk
- reset_n  in  1  asynchronous active-low reset
- hpos  in  10  current pixel column from hdmi
- vpos  in  10  current line from hdmi
- cpu_req  in  1  request valid; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  byte address
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-cycle pulse; request completed (write queued, or read data valid)
- cpu_rdata  out  8  read data; valid only while cpu_ack=1 for a read
- wfifo_full  out  1  FIFO holds WFIFO_DEPTH entries
- mem_addr  out  ADDR_WIDTH  VRAM address
- mem_we  out  1  VRAM write strobe
- mem_wdata  out  8  VRAM write data
- mem_rdata  in  8  VRAM read data, one cycle after address
- pix_index  out  8  palette index for the scanout pixel
- pix_valid  out  1  pix_index belongs to the active area

Behaviour:
- Reset: all outputs are 0 and the FIFO is emptied. An asynchronous assert mid-operation discards queued writes and any in-flight read, and clears the pixel pipeline. No ack is issued for a request that is pending at reset.
- Signal definitions:
  - active = (hpos < H_ACTIVE) && (vpos < V_ACTIVE); blank = !active.
  - vid_slot = active && hpos[1:0]==0.
  - vaddr = (vpos>>2)*FB_WIDTH + (hpos>>2), computed at ADDR_WIDTH bits as a constant multiply.
- Slot priority, evaluated every cycle:
  1. Video fetch: if vid_slot, mem_addr=vaddr and mem_we=0.
  2. CPU read: if cpu_req && !cpu_we && FIFO empty && !ack_pending, issue mem_addr=cpu_addr.
  3. Write retire: if FIFO non-empty and (blank || !WRITE_IN_BLANK_ONLY), pop the head to mem_addr/mem_wdata with mem_we=1.
  4. Otherwise mem_we=0 and mem_addr holds its last value.
- mem_addr, mem_we and mem_wdata are combinational from registered state and hpos/vpos.
- Pixel pipeline:
  - Fetch at cycle t; mem_rdata is registered into pix_index at t+2 and held until the next fetch.
  - pix_valid = active delayed 2 cycles.
  - Fixed latency 2; downstream compensates.
- CPU write:
  - Accepted when cpu_req && cpu_we && !wfifo_full && !ack_pending; push {addr, data}.
  - cpu_ack pulses the next cycle.
  - No bypass: an accepted write retires no earlier than the cycle after the push.
- CPU read:
  - cpu_ack and cpu_rdata (=mem_rdata) are asserted the cycle after issue.
  - Reads wait while the FIFO is non-empty, so a read always returns the latest write (read-after-write ordering).
- ack_pending is high in the cycle cpu_ack=1; no new request is accepted that cycle, preventing double acceptance while the requester still drives cpu_req.
- Simultaneous push and pop: both happen and the count is unchanged. A full FIFO does not accept a push in the same cycle as a pop; the writer waits one cycle.
- FIFO pointers wrap modulo WFIFO_DEPTH; count is log2(WFIFO_DEPTH)+1 bits.
- Because video fetches only occur while active, a blank period retires one write per cycle.

Test Plan:
- Reset: drive reset_n=0 with random inputs -> all outputs 0; release -> pix_valid=0 until an active fetch has passed through the pipeline.
- Scanout: hpos=8, vpos=4 -> mem_addr=162, mem_we=0 that cycle; mem_rdata=0x5A -> pix_index=0x5A and pix_valid=1 two cycles later.
- Blank-only write: at vpos=10, hpos=100, write addr 0x0123=0x77 -> cpu_ack the next cycle; mem_we stays 0 until hpos=640, then mem_we=1 with addr 0x0123 and data 0x77.
- FIFO full: 17 back-to-back writes during active video -> 16 acks and wfifo_full=1; the 17th is held without ack until hpos=640. Then writes retire in order one per cycle, and the 17th is acked after the first pop.
- Read ordering: write addr 100=0x33 during active, then read addr 100 -> no ack until the FIFO drains in blank; the read then acks with cpu_rdata=0x33. A read issued with the FIFO empty in active video, colliding with hpos[1:0]==0, is delayed exactly 1 cycle.
- Reset mid-operation: with 5 queued writes, pulse reset_n low -> FIFO empty, no mem_we afterwards, cpu_ack=0.
